// File: rtl/mgt_01_mul_arbiter_pkg.sv
// Shared types and constants for the multiplier-sharing controller and its
// round-robin arbiter.
package mgt_01_mul_arbiter_pkg;

  localparam int XLEN      = 32;
  localparam int TAG_W     = 5;
  localparam int MUL_REQ_N = 2;

  typedef enum logic [1:0] {
    MUL_   = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_ops_e;

  localparam int OP_W = $bits(mul_ops_e);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    mul_ops_e         op;
    logic [TAG_W-1:0] tag;
  } mul_req_t;

endpackage

// File: rtl/mgt_01_rr_arbiter2.sv
// Two-input round-robin grant. A sole requester always wins; on a tie the
// pointer picks, and after every grant the pointer moves to the other input.
module mgt_01_rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       clk_en_i,
  input  logic       arb_en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt_id_o = (req_i == 2'b11) ? ptr_q : req_i[1];
    gnt_o    = (arb_en_i && (req_i != 2'b00)) ? {gnt_id_o, ~gnt_id_o} : 2'b00;
    ptr_d    = ptr_q;
    if (gnt_o != 2'b00) begin
      ptr_d = ~gnt_id_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q <= 1'b0;
    end else if (clk_en_i) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mgt_01_mul_arbiter.sv
// Shares one multiplier between the integer pipe (port 0) and the FPU
// mantissa path (port 1): accept, issue, wait for the result, respond.
module mgt_01_mul_arbiter
  import mgt_01_mul_arbiter_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      clk_en_i,
  input  logic [MUL_REQ_N-1:0]      req_valid_i,
  output logic [MUL_REQ_N-1:0]      req_ready_o,
  input  logic [2*XLEN-1:0]         req_a_i,
  input  logic [2*XLEN-1:0]         req_b_i,
  input  logic [2*OP_W-1:0]         req_op_i,
  input  logic [2*TAG_W-1:0]        req_tag_i,
  input  logic                      kill_i,
  output logic                      mul_start_o,
  output logic [XLEN-1:0]           mul_a_o,
  output logic [XLEN-1:0]           mul_b_o,
  output logic [OP_W-1:0]           mul_op_o,
  input  logic                      mul_valid_i,
  input  logic [XLEN-1:0]           mul_result_i,
  output logic [MUL_REQ_N-1:0]      rsp_valid_o,
  input  logic [MUL_REQ_N-1:0]      rsp_ready_i,
  output logic [XLEN-1:0]           rsp_result_o,
  output logic [TAG_W-1:0]          rsp_tag_o,
  output logic                      busy_o,
  output logic [1:0]                dbg_state_o
);

  arb_state_e      state_q, state_d;
  mul_req_t        req_q, req_d;
  logic            owner_q, owner_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [1:0]      gnt;
  logic            gnt_id;
  logic            kill_int;

  // Kill only ever targets an operation owned by the integer pipe.
  assign kill_int = kill_i && !owner_q;

  mgt_01_rr_arbiter2 u_rr (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clk_en_i (clk_en_i),
    .arb_en_i ((state_q == IDLE) && clk_en_i),
    .req_i    (req_valid_i),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  // Handshakes: a transfer happens on a rising clk_i (with clk_en_i=1) where
  // valid and ready are both high. Request side: ready is the grant, offered
  // only in IDLE. Response side: rsp_valid_o[owner] holds with stable
  // result/tag until rsp_ready_i[owner] is seen; it never waits on ready.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    owner_d     = owner_q;
    drop_d      = drop_q;
    result_d    = result_q;
    mul_start_o = 1'b0;
    rsp_valid_o = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          owner_d   = gnt_id;
          req_d.a   = gnt_id ? req_a_i[2*XLEN-1:XLEN] : req_a_i[XLEN-1:0];
          req_d.b   = gnt_id ? req_b_i[2*XLEN-1:XLEN] : req_b_i[XLEN-1:0];
          req_d.op  = mul_ops_e'(gnt_id ? req_op_i[2*OP_W-1:OP_W] : req_op_i[OP_W-1:0]);
          req_d.tag = gnt_id ? req_tag_i[2*TAG_W-1:TAG_W] : req_tag_i[TAG_W-1:0];
          drop_d    = kill_i && !gnt_id;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        mul_start_o = clk_en_i;
        if (kill_int) begin
          drop_d = 1'b1;
        end
        state_d = WAIT;
      end
      WAIT: begin
        if (kill_int) begin
          drop_d = 1'b1;
        end
        if (mul_valid_i) begin
          result_d = mul_result_i;
          state_d  = (drop_q || kill_int) ? IDLE : RESP;
        end
      end
      RESP: begin
        if (kill_int) begin
          state_d = IDLE;
        end else begin
          rsp_valid_o[owner_q] = 1'b1;
          if (rsp_ready_i[owner_q]) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      req_q    <= '0;
      owner_q  <= 1'b0;
      drop_q   <= 1'b0;
      result_q <= '0;
    end else if (clk_en_i) begin
      state_q  <= state_d;
      req_q    <= req_d;
      owner_q  <= owner_d;
      drop_q   <= drop_d;
      result_q <= result_d;
    end
  end

  assign req_ready_o  = gnt;
  assign mul_a_o      = req_q.a;
  assign mul_b_o      = req_q.b;
  assign mul_op_o     = req_q.op;
  assign rsp_result_o = result_q;
  assign rsp_tag_o    = req_q.tag;
  assign busy_o       = (state_q != IDLE);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mgt_01_mul_arbiter.sv
// Bench for mgt_01_mul_arbiter: behavioural multiplier with variable latency,
// response scoreboard, op table plus hand-written arbitration/kill/reset cases.
module tb_mgt_01_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_op;
  logic [9:0]  req_tag;
  logic        kill;
  logic        mul_start;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [1:0]  mul_op;
  logic        mul_valid;
  logic [31:0] mul_result;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_tag;
  logic        busy;
  logic [1:0]  dbg_state;

  int tests_run = 0;
  int failures  = 0;
  logic [37:0] exp_q[$];
  int          start_cnt = 0;
  int          mul_cnt   = 0;
  int          mul_lat   = 8;
  logic [31:0] mul_pend  = '0;

  typedef struct {
    int          port;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [4:0]  tag;
    logic [31:0] exp_res;
  } vec_t;
  vec_t vecs[7];

  mgt_01_mul_arbiter dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .clk_en_i     (clk_en),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_op_i     (req_op),
    .req_tag_i    (req_tag),
    .kill_i       (kill),
    .mul_start_o  (mul_start),
    .mul_a_o      (mul_a),
    .mul_b_o      (mul_b),
    .mul_op_o     (mul_op),
    .mul_valid_i  (mul_valid),
    .mul_result_i (mul_result),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_result_o (rsp_result),
    .rsp_tag_o    (rsp_tag),
    .busy_o       (busy),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
    logic [63:0] p;
    case (op)
      2'd1:    p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      2'd2:    p = {{32{a[31]}}, a} * {32'd0, b};
      default: p = {32'd0, a} * {32'd0, b};
    endcase
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int p, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op, input logic [4:0] tag);
    req_valid[p]       = 1'b1;
    req_a[p*32 +: 32]  = a;
    req_b[p*32 +: 32]  = b;
    req_op[p*2 +: 2]   = op;
    req_tag[p*5 +: 5]  = tag;
  endtask

  task automatic wait_accept(input int p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready[p]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic push_exp(input int p, input logic [4:0] tag, input logic [31:0] res);
    logic [31:0] pv;
    pv = p;
    exp_q.push_back({pv[0], tag, res});
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !busy) break;
    end
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  // ---------------- multiplier model ----------------
  always @(negedge clk) begin
    if (rst_n && mul_start) begin
      check("start_valid_overlap", mul_valid, 1'b0);
      start_cnt++;
      mul_cnt  = mul_lat;
      mul_pend = mul_model(mul_a, mul_b, mul_op);
    end
  end

  always @(posedge clk) begin
    #1;
    mul_valid = 1'b0;
    if (mul_cnt > 0) begin
      mul_cnt--;
      if (mul_cnt == 0) begin
        mul_valid  = 1'b1;
        mul_result = mul_pend;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_onehot", req_ready == 2'b11, 1'b0);
      check("rsp_onehot", rsp_valid == 2'b11, 1'b0);
      for (int p = 0; p < 2; p++) begin
        if (rsp_valid[p] && rsp_ready[p]) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 1'b1, 1'b0);
          end else begin
            logic [37:0] e;
            logic [31:0] pv;
            pv = p;
            e  = exp_q.pop_front();
            check("rsp_port_tag_result", {pv[0], rsp_tag, rsp_result}, e);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    bit seen;
    int s0;

    vecs[0] = '{0, 32'd7,        32'hFFFF_FFFD, 2'd0, 5'd4,  32'hFFFF_FFEB};
    vecs[1] = '{1, 32'd7,        32'hFFFF_FFFD, 2'd1, 5'd11, 32'hFFFF_FFFF};
    vecs[2] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd3, 5'd2,  32'hFFFF_FFFE};
    vecs[3] = '{1, 32'hFFFF_FFFF, 32'd2,        2'd2, 5'd17, 32'hFFFF_FFFF};
    vecs[4] = '{0, 32'h0001_0000, 32'h0001_0000, 2'd0, 5'd31, 32'h0000_0000};
    vecs[5] = '{1, 32'h0001_0000, 32'h0001_0000, 2'd3, 5'd0,  32'h0000_0001};
    vecs[6] = '{0, 32'h1234_5678, 32'h10,       2'd0, 5'd7,  32'h2345_6780};

    rst_n = 1'b0; clk_en = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    req_op = '0; req_tag = '0; kill = 1'b0; rsp_ready = 2'b11;
    mul_valid = 1'b0; mul_result = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {req_ready, mul_start, rsp_valid, busy, dbg_state, mul_op, rsp_tag}, 0);
    check("reset_data", {mul_a, rsp_result}, 0);
    check("reset_mul_b", mul_b, 0);
    rst_n = 1'b1;

    // T1: single integer request, exact response timing
    mul_lat = 8; s0 = start_cnt;
    step; drive_req(0, 32'd7, 32'hFFFF_FFFD, 2'd0, 5'd4);
    wait_accept(0, ok); check("t1_accept", ok, 1);
    push_exp(0, 5'd4, 32'hFFFF_FFEB);
    step; req_valid = '0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (mul_valid) begin
        check("t1_rsp_before_valid", rsp_valid, 2'b00);
        @(negedge clk);
        check("t1_rsp_valid", rsp_valid, 2'b01);
        check("t1_rsp_tag", rsp_tag, 5'd4);
        seen = 1'b1;
      end
    end
    check("t1_mul_valid_seen", seen, 1);
    drain("t1");
    check("t1_one_start", start_cnt - s0, 1);

    // Table: one request per op/port with random multiplier latency
    for (int v = 0; v < 7; v++) begin
      mul_lat = $urandom_range(1, 6); s0 = start_cnt;
      step; drive_req(vecs[v].port, vecs[v].a, vecs[v].b, vecs[v].op, vecs[v].tag);
      wait_accept(vecs[v].port, ok); check($sformatf("vec%0d_accept", v), ok, 1);
      push_exp(vecs[v].port, vecs[v].tag, vecs[v].exp_res);
      step; req_valid = '0;
      drain($sformatf("vec%0d", v));
      check($sformatf("vec%0d_one_start", v), start_cnt - s0, 1);
    end

    // T2: simultaneous requests alternate, starting with port 0 after reset
    step; rst_n = 1'b0; step; step; rst_n = 1'b1;
    mul_lat = 3;
    step; drive_req(0, 32'd5, 32'd6, 2'd0, 5'd1); drive_req(1, 32'd9, 32'd3, 2'd0, 5'd2);
    @(negedge clk); check("t2_first_grant", req_ready, 2'b01);
    push_exp(0, 5'd1, 32'd30);
    step; req_valid[0] = 1'b0;
    wait_accept(1, ok); check("t2_second_accept", ok, 1);
    push_exp(1, 5'd2, 32'd27);
    step; req_valid[1] = 1'b0;
    drain("t2a");
    step; drive_req(0, 32'd2, 32'd8, 2'd0, 5'd3); drive_req(1, 32'd3, 32'd3, 2'd0, 5'd4);
    @(negedge clk); check("t2_third_grant", req_ready, 2'b01);
    push_exp(0, 5'd3, 32'd16);
    step; req_valid[0] = 1'b0;
    wait_accept(1, ok); check("t2_fourth_accept", ok, 1);
    push_exp(1, 5'd4, 32'd9);
    step; req_valid[1] = 1'b0;
    drain("t2b");

    // T3: FPU response held off for 5 cycles with an integer request waiting
    mul_lat = 2; rsp_ready = 2'b01;
    step; drive_req(1, 32'h0001_2345, 32'h100, 2'd0, 5'd9);
    wait_accept(1, ok); check("t3_accept", ok, 1);
    push_exp(1, 5'd9, 32'h0123_4500);
    step; req_valid[1] = 1'b0; drive_req(0, 32'd4, 32'd4, 2'd0, 5'd12);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid[1]) begin seen = 1'b1; break; end
    end
    check("t3_rsp_seen", seen, 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("t3_hold_result", rsp_result, 32'h0123_4500);
      check("t3_hold_tag", rsp_tag, 5'd9);
      check("t3_hold_valid", rsp_valid, 2'b10);
      check("t3_no_ready_in_resp", req_ready, 2'b00);
    end
    step; rsp_ready = 2'b11;
    @(negedge clk); check("t3_no_ready_on_handshake", req_ready, 2'b00);
    @(negedge clk); check("t3_accept_after_handshake", req_ready, 2'b01);
    push_exp(0, 5'd12, 32'd16);
    step; req_valid[0] = 1'b0;
    drain("t3");

    // T4: kill in WAIT drops the integer op; pending FPU request follows
    mul_lat = 6;
    step; drive_req(0, 32'd11, 32'd13, 2'd0, 5'd3);
    wait_accept(0, ok); check("t4_accept", ok, 1);
    step; req_valid[0] = 1'b0; drive_req(1, 32'd21, 32'd2, 2'd0, 5'd8);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dbg_state == 2'd2) begin seen = 1'b1; break; end
    end
    check("t4_in_wait", seen, 1);
    step; kill = 1'b1; step; kill = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t4_no_rsp", rsp_valid, 2'b00);
      if (mul_valid) begin seen = 1'b1; break; end
    end
    check("t4_mul_valid_seen", seen, 1);
    @(negedge clk);
    check("t4_idle_after_valid", dbg_state, 2'd0);
    check("t4_fpu_granted", req_ready, 2'b10);
    push_exp(1, 5'd8, 32'd42);
    step; req_valid[1] = 1'b0;
    drain("t4");

    // T5: kill has no effect on an FPU operation
    mul_lat = 4;
    step; kill = 1'b1; drive_req(1, 32'd100, 32'd3, 2'd0, 5'd21);
    wait_accept(1, ok); check("t5_accept", ok, 1);
    push_exp(1, 5'd21, 32'd300);
    step; req_valid[1] = 1'b0;
    drain("t5");
    step; kill = 1'b0;

    // T6: asynchronous reset during WAIT, stray valid ignored, gated clock
    mul_lat = 8;
    step; drive_req(0, 32'd6, 32'd7, 2'd0, 5'd5);
    wait_accept(0, ok); check("t6_accept", ok, 1);
    step; req_valid = '0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dbg_state == 2'd2) begin seen = 1'b1; break; end
    end
    check("t6_in_wait", seen, 1);
    step; step;
    rst_n = 1'b0;
    #1;
    check("t6_rst_ctrl", {req_ready, mul_start, rsp_valid, busy, dbg_state, mul_op, rsp_tag}, 0);
    check("t6_rst_data", {mul_a, rsp_result}, 0);
    check("t6_rst_mul_b", mul_b, 0);
    step; step; rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mul_valid) seen = 1'b1;
      check("t6_idle_after_reset", {rsp_valid, busy, dbg_state}, 0);
    end
    check("t6_stray_valid_seen", seen, 1);
    step; clk_en = 1'b0; drive_req(0, 32'd8, 32'd8, 2'd0, 5'd6);
    @(negedge clk); check("t6_gated_ready", req_ready, 2'b00);
    step;
    @(negedge clk); check("t6_gated_state", {dbg_state, busy}, 0);
    step; clk_en = 1'b1;
    wait_accept(0, ok); check("t6_accept_after_reset", ok, 1);
    push_exp(0, 5'd6, 32'd64);
    step; req_valid = '0;
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
